// File: rtl/ats21_cmd_capture.sv
// ats21_cmd_capture: assembles two-word instructions from clients A/B into a dual-push FWFT command queue
module ats21_cmd_capture #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req,
  input  logic [15:0]                  ctrlA,
  input  logic [15:0]                  ctrlB,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [31:0]                  cmd_word,
  output logic                         cmd_client,
  output logic [$clog2(DEPTH+1)-1:0]   q_level,
  output logic                         busy,
  output logic                         overflow,
  output logic [CNT_W-1:0]             drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  typedef enum logic {IDLE, LOWER} state_t;
  state_t state_a, state_a_n, state_b, state_b_n;
  logic [15:0] upper_a, upper_b;
  logic cap_a, cap_b, push_a, push_b, pop, acc_a, acc_b;
  logic [LW-1:0] free;
  logic [1:0] n_acc, n_drop;
  logic [CNT_W:0] drop_sum;
  logic [31:0] mem_word [DEPTH];
  logic mem_client [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_comb begin
    push_a = state_a == LOWER;
    push_b = state_b == LOWER;
    cap_a = state_a == IDLE && req && |ctrlA[15:13];
    cap_b = state_b == IDLE && req && |ctrlB[15:13];
    state_a_n = cap_a ? LOWER : IDLE;
    state_b_n = cap_b ? LOWER : IDLE;
    pop = cmd_valid & cmd_ready;
    // a pop this edge frees its slot for a same-edge push; A has priority over B
    free = LW'(DEPTH) - q_level + LW'(pop);
    acc_a = push_a && free != '0;
    acc_b = push_b && free > LW'(acc_a);
    n_acc = 2'(acc_a) + 2'(acc_b);
    n_drop = 2'(push_a) + 2'(push_b) - n_acc;
    drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(n_drop);
  end
  assign cmd_valid = q_level != '0;
  assign cmd_word = cmd_valid ? mem_word[rd_ptr] : '0;
  assign cmd_client = cmd_valid ? mem_client[rd_ptr] : 1'b0;
  assign busy = state_a == LOWER || state_b == LOWER;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_a <= IDLE;
      state_b <= IDLE;
      upper_a <= '0;
      upper_b <= '0;
    end else begin
      state_a <= state_a_n;
      state_b <= state_b_n;
      upper_a <= cap_a ? ctrlA : upper_a;
      upper_b <= cap_b ? ctrlB : upper_b;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_word[i] <= '0;
        mem_client[i] <= 1'b0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_level <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (acc_a) begin
        mem_word[wr_ptr] <= {upper_a, ctrlA};
        mem_client[wr_ptr] <= 1'b0;
      end
      if (acc_b) begin
        mem_word[wr_ptr + AW'(acc_a)] <= {upper_b, ctrlB};
        mem_client[wr_ptr + AW'(acc_a)] <= 1'b1;
      end
      wr_ptr <= wr_ptr + AW'(n_acc);
      rd_ptr <= rd_ptr + AW'(pop);
      q_level <= q_level + LW'(n_acc) - LW'(pop);
      overflow <= n_drop != '0;
      drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_ats21_cmd_capture.sv
// tb_ats21_cmd_capture: directed + random stimulus checked against a queue-based reference model
module tb_ats21_cmd_capture;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  logic clk = 0, reset = 0, req = 0, cmd_ready = 0;
  logic [15:0] ctrlA = 0, ctrlB = 0;
  logic cmd_valid, cmd_client, busy, overflow;
  logic [31:0] cmd_word;
  logic [$clog2(DEPTH+1)-1:0] q_level;
  logic [CNT_W-1:0] drop_cnt;
  ats21_cmd_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_word(cmd_word),
    .cmd_client(cmd_client), .q_level(q_level), .busy(busy),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [31:0] w; logic c;} ent_t;
  ent_t mq[$];
  bit pa, pb, movf;
  logic [15:0] ua, ub;
  int mdrop, n_vec, n_err;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    mq.delete();
    pa = 0;
    pb = 0;
    movf = 0;
    mdrop = 0;
  endtask
  // one clock edge of the reference: pop, then enqueue completed A then B where room remains
  task automatic model_edge();
    bit ca, cb;
    int d;
    ent_t tmp;
    ca = pa;
    cb = pb;
    d = 0;
    if (mq.size() > 0 && cmd_ready) tmp = mq.pop_front();
    if (ca) begin
      if (mq.size() < DEPTH) mq.push_back('{w: {ua, ctrlA}, c: 1'b0}); else d++;
    end
    if (cb) begin
      if (mq.size() < DEPTH) mq.push_back('{w: {ub, ctrlB}, c: 1'b1}); else d++;
    end
    mdrop = (mdrop + d > 255) ? 255 : mdrop + d;
    movf = d > 0;
    if (ca) pa = 0; else if (req && ctrlA[15:13] != 3'b000) begin pa = 1; ua = ctrlA; end
    if (cb) pb = 0; else if (req && ctrlB[15:13] != 3'b000) begin pb = 1; ub = ctrlB; end
  endtask
  task automatic check_all();
    chk("cmd_valid", 32'(cmd_valid), 32'(mq.size() > 0));
    chk("q_level", 32'(q_level), 32'(mq.size()));
    chk("busy", 32'(busy), 32'(pa | pb));
    chk("overflow", 32'(overflow), 32'(movf));
    chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
    if (mq.size() > 0) begin
      chk("cmd_word", cmd_word, mq[0].w);
      chk("cmd_client", 32'(cmd_client), 32'(mq[0].c));
    end
  endtask
  task automatic step(input logic r, input logic [15:0] a, input logic [15:0] b, input logic rdy);
    req = r;
    ctrlA = a;
    ctrlB = b;
    cmd_ready = rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_word", cmd_word, 32'h0);
    chk("rst_valid", 32'(cmd_valid), 32'h0);
    reset = 1;
    step(1, 16'h2000, 16'h0000, 0);
    chk("t1_nvalid", 32'(cmd_valid), 32'h0);
    step(0, 16'h0000, 16'h0000, 0);
    chk("t1_word", cmd_word, 32'h2000_0000);
    chk("t1_client", 32'(cmd_client), 32'h0);
    step(0, 16'h0000, 16'h0000, 1);
    step(1, 16'h2000, 16'h2240, 0);
    step(0, 16'h0000, 16'h0000, 0);
    chk("t2_level", 32'(q_level), 32'h2);
    chk("t2_headA", cmd_word, 32'h2000_0000);
    step(0, 16'h0000, 16'h0000, 1);
    chk("t2_headB", cmd_word, 32'h2240_0000);
    chk("t2_clientB", 32'(cmd_client), 32'h1);
    step(0, 16'h0000, 16'h0000, 1);
    step(1, 16'h4111, 16'h0000, 0);
    step(1, 16'h0222, 16'h6333, 0);
    chk("t3_headA", cmd_word, 32'h4111_0222);
    step(0, 16'h0000, 16'h0444, 0);
    chk("t3_level", 32'(q_level), 32'h2);
    repeat (2) step(0, 16'h0000, 16'h0000, 1);
    step(1, 16'h2001, 16'h0000, 0);
    step(0, 16'h0001, 16'h0000, 0);
    step(1, 16'h2002, 16'hC002, 0);
    step(0, 16'h0002, 16'h0012, 0);
    step(1, 16'h2003, 16'hC003, 0);
    step(0, 16'h0003, 16'h0013, 0);
    chk("t4_level", 32'(q_level), 32'h4);
    chk("t4_drop", 32'(drop_cnt), 32'h1);
    chk("t4_ovf", 32'(overflow), 32'h1);
    step(1, 16'h2004, 16'h0000, 0);
    chk("t4_ovf_end", 32'(overflow), 32'h0);
    step(0, 16'h0004, 16'h0000, 1);
    chk("t5_level", 32'(q_level), 32'h4);
    chk("t5_drop", 32'(drop_cnt), 32'h1);
    chk("t5_head", cmd_word, 32'h2002_0002);
    repeat (4) step(0, 16'h0000, 16'h0000, 1);
    step(1, 16'hA100, 16'h0000, 0);
    chk("t6_busy", 32'(busy), 32'h1);
    reset = 0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1;
    step(1, 16'h0000, 16'h0000, 0);
    chk("t6_nbusy", 32'(busy), 32'h0);
    step(0, 16'h1234, 16'h0000, 0);
    chk("t6_empty", 32'(q_level), 32'h0);
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(3) == 0) a[15:13] = 3'b000;
      if ($urandom_range(3) == 0) b[15:13] = 3'b000;
      step(1'($urandom_range(1)), a, b, 1'($urandom_range(2) == 0));
    end
    for (int i = 0; i < 150; i++) begin
      step(1, 16'hE000 | 16'(i), 16'hF000 | 16'(i), 0);
      step(0, 16'(i), 16'(~i), 0);
    end
    chk("sat_drop", 32'(drop_cnt), 32'hFF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
